// File: rtl/nav_pkg.sv
// Shared types and step-size helper for the maze navigation sequencer.
package nav_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HEADING  = 3'd1,
        ACCEL    = 3'd2,
        CRUISE   = 3'd3,
        STOP     = 3'd4,
        FASTSTOP = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_HDNG_OK = 2'd0,
        CAUSE_OPENING = 2'd1,
        CAUSE_BLOCKED = 2'd2,
        CAUSE_ABORT   = 2'd3
    } cause_t;

    // Large step shortens simulated ramps; small step is the real-robot rate.
    function automatic logic [5:0] acc_inc_sel(input bit fast_sim);
        return fast_sim ? 6'h18 : 6'h02;
    endfunction

endpackage

// File: rtl/nav_edge_det.sv
// Rising-edge detector; history resets high so a level present at reset is not a rise.
module nav_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic prev_reg;

    always_ff @(posedge clk) begin
        if (rst) prev_reg <= 1'b1;
        else     prev_reg <= sig;
    end

    assign rise = sig & ~prev_reg;

endmodule

// File: rtl/nav_ramp_ctrl.sv
// Navigation sequencer: heading changes and forward moves with ramped speed,
// skip-N-openings stops, abort, heading timeout and a registered stop-cause report.
module nav_ramp_ctrl
    import nav_pkg::*;
#(
    parameter int               FAST_SIM   = 1,
    parameter int               SPD_W      = 11,
    parameter logic [SPD_W-1:0] MAX_SPD    = 'h2A0,
    parameter logic [SPD_W-1:0] MIN_SPD    = 'h0D0,
    parameter int               NRM_DEC_SH = 1,
    parameter int               FST_DEC_SH = 3,
    parameter int               CNT_W      = 3,
    parameter int               TMO_W      = 12,
    parameter int               HDNG_TMO   = 2000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strt_hdng,
    input  logic             strt_mv,
    input  logic             stp_lft,
    input  logic             stp_rght,
    input  logic [CNT_W-1:0] skip_cnt,
    input  logic             abort,
    input  logic             hdng_rdy,
    input  logic             at_hdng,
    input  logic             lft_opn,
    input  logic             rght_opn,
    input  logic             frwrd_opn,
    output logic [SPD_W-1:0] frwrd_spd,
    output logic             moving,
    output logic             en_fusion,
    output logic             mv_cmplt,
    output logic             hdng_tmout,
    output logic [1:0]       stop_cause
);

    localparam logic [SPD_W-1:0] ACC_STEP = SPD_W'(acc_inc_sel(FAST_SIM != 0));
    localparam logic [SPD_W-1:0] NRM_STEP = ACC_STEP << NRM_DEC_SH;
    localparam logic [SPD_W-1:0] FST_STEP = ACC_STEP << FST_DEC_SH;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(HDNG_TMO - 1);

    state_t             state_reg, state_next;
    logic [SPD_W-1:0]   spd_reg, spd_next;
    logic [CNT_W-1:0]   skip_reg, skip_next;
    logic [TMO_W-1:0]   tmo_reg, tmo_next;
    cause_t             cause_reg, cause_next;
    logic               mv_cmplt_reg, mv_cmplt_next;
    logic               tmout_reg, tmout_next;

    logic [1:0] opn_vec, rise_vec;
    logic       qual_rise;
    logic [SPD_W:0]   acc_sum;
    logic [SPD_W-1:0] acc_sat, dec_nrm, dec_fst;

    assign opn_vec = {rght_opn, lft_opn};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_edge
            nav_edge_det u_edge (
                .clk  (clk),
                .rst  (rst),
                .sig  (opn_vec[gi]),
                .rise (rise_vec[gi])
            );
        end
    endgenerate

    assign qual_rise = (stp_lft & rise_vec[0]) | (stp_rght & rise_vec[1]);

    // Widened add so saturation is detected before any wrap.
    assign acc_sum = {1'b0, spd_reg} + {1'b0, ACC_STEP};
    assign acc_sat = (acc_sum >= {1'b0, MAX_SPD}) ? MAX_SPD : acc_sum[SPD_W-1:0];
    assign dec_nrm = (spd_reg > NRM_STEP) ? spd_reg - NRM_STEP : '0;
    assign dec_fst = (spd_reg > FST_STEP) ? spd_reg - FST_STEP : '0;

    always_comb begin
        state_next    = state_reg;
        spd_next      = spd_reg;
        skip_next     = skip_reg;
        tmo_next      = tmo_reg;
        cause_next    = cause_reg;
        mv_cmplt_next = 1'b0;
        tmout_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (strt_mv) begin
                    state_next = ACCEL;
                    spd_next   = MIN_SPD;
                    skip_next  = skip_cnt;
                    cause_next = CAUSE_HDNG_OK;
                end else if (strt_hdng) begin
                    state_next = HEADING;
                    tmo_next   = '0;
                end
            end
            HEADING: begin
                if (abort) begin
                    state_next    = IDLE;
                    cause_next    = CAUSE_ABORT;
                    mv_cmplt_next = 1'b1;
                end else if (at_hdng) begin
                    state_next    = IDLE;
                    cause_next    = CAUSE_HDNG_OK;
                    mv_cmplt_next = 1'b1;
                end else if (hdng_rdy) begin
                    if (tmo_reg == TMO_LAST) begin
                        state_next    = IDLE;
                        cause_next    = CAUSE_ABORT;
                        mv_cmplt_next = 1'b1;
                        tmout_next    = 1'b1;
                    end else begin
                        tmo_next = tmo_reg + 1'b1;
                    end
                end
            end
            ACCEL, CRUISE: begin
                // An exit cycle holds speed; deceleration starts on the next hdng_rdy.
                if (abort) begin
                    state_next = FASTSTOP;
                    cause_next = CAUSE_ABORT;
                end else if (!frwrd_opn) begin
                    state_next = FASTSTOP;
                    cause_next = CAUSE_BLOCKED;
                end else if (qual_rise && skip_reg == '0) begin
                    state_next = STOP;
                    cause_next = CAUSE_OPENING;
                end else begin
                    if (qual_rise) skip_next = skip_reg - 1'b1;
                    if (hdng_rdy)  spd_next  = acc_sat;
                    if (spd_reg == MAX_SPD) state_next = CRUISE;
                end
            end
            STOP: begin
                if (spd_reg == '0) begin
                    state_next    = IDLE;
                    mv_cmplt_next = 1'b1;
                end else if (abort) begin
                    state_next = FASTSTOP;
                end else if (hdng_rdy) begin
                    spd_next = dec_nrm;
                end
            end
            FASTSTOP: begin
                if (spd_reg == '0) begin
                    state_next    = IDLE;
                    mv_cmplt_next = 1'b1;
                end else if (hdng_rdy) begin
                    spd_next = dec_fst;
                end
            end
            default: state_next = FASTSTOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            spd_reg      <= '0;
            skip_reg     <= '0;
            tmo_reg      <= '0;
            cause_reg    <= CAUSE_HDNG_OK;
            mv_cmplt_reg <= 1'b0;
            tmout_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            spd_reg      <= spd_next;
            skip_reg     <= skip_next;
            tmo_reg      <= tmo_next;
            cause_reg    <= cause_next;
            mv_cmplt_reg <= mv_cmplt_next;
            tmout_reg    <= tmout_next;
        end
    end

    assign frwrd_spd  = spd_reg;
    assign en_fusion  = spd_reg > (MAX_SPD >> 1);
    assign mv_cmplt   = mv_cmplt_reg;
    assign hdng_tmout = tmout_reg;
    assign stop_cause = cause_reg;
    assign moving     = (state_reg == HEADING) || (state_reg == ACCEL) || (state_reg == CRUISE) ||
                        (((state_reg == STOP) || (state_reg == FASTSTOP)) && spd_reg != '0);

endmodule
